// File: rtl/spi_wrapper.sv
// SPI slave bridged to a byte-wide RAM.
// A frame is SS_n low, one command bit, then a 10-bit word whose top two bits
// select the RAM operation. Read data returns on MISO eight bits at a time,
// MSB first, in the same frame that requested it.

module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss_n,
    input  logic       mosi,
    input  logic [7:0] dout,
    input  logic       tx_valid,
    output logic       miso,
    output logic [9:0] rx_data,
    output logic       rx_valid
);
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Bit counter milestones within a frame (counter value before the edge).
    // 0..9   : receiving word bits (E1..E10)
    // 10     : word received, waiting for read data from the RAM
    // 11..17 : shifting out read bits 6..0 (bit 7 goes out on the load edge)
    // 18     : read data fully sent, hold until SS_n rises
    localparam logic [4:0] RX_LAST  = 5'd9;
    localparam logic [4:0] RX_DONE  = 5'd10;
    localparam logic [4:0] TX_FIRST = 5'd11;
    localparam logic [4:0] TX_LAST  = 5'd17;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [8:0]  shreg;      // first nine word bits; the tenth comes straight from MOSI
    logic [7:0]  tx_shift;
    logic        rd_flag;    // set once a read address has been sent, cleared after read data

    logic        framed;
    logic        abort;
    logic        shift_en;
    logic        rx_last;
    logic        tx_load;
    logic        tx_shift_en;
    logic        tx_last;

    // State register: synchronous reset back to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: SS_n high drops any frame; the command bit picks the branch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!ss_n) begin
                    state_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (ss_n) begin
                    state_next = IDLE;
                end else if (!mosi) begin
                    state_next = WRITE;
                end else if (rd_flag) begin
                    state_next = READ_DATA;
                end else begin
                    state_next = READ_ADD;
                end
            end
            default: begin
                if (ss_n) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Output decode: per-edge control strobes for the datapath below.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        framed      = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
        abort       = (state != IDLE) && ss_n;
        shift_en    = framed && !ss_n && (cnt < RX_DONE);
        rx_last     = shift_en && (cnt == RX_LAST);
        tx_load     = (state == READ_DATA) && !ss_n && (cnt == RX_DONE) && tx_valid;
        tx_shift_en = (state == READ_DATA) && !ss_n && (cnt >= TX_FIRST) && (cnt <= TX_LAST);
        tx_last     = tx_shift_en && (cnt == TX_LAST);
    end

    // Datapath: receive shifting, rx_valid pulse, read-flag tracking and MISO shifting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rd_flag  <= 1'b0;
            miso     <= 1'b0;
            tx_shift <= '0;
        end else begin
            // Pulses and MISO default low; only an active transmit edge drives a bit.
            rx_valid <= 1'b0;
            miso     <= 1'b0;
            if (abort) begin
                cnt <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[7:0], mosi};
                cnt   <= cnt + 5'd1;
                if (rx_last) begin
                    rx_data  <= {shreg, mosi};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD) begin
                        rd_flag <= 1'b1;
                    end
                end
            end else if (tx_load) begin
                tx_shift <= {dout[6:0], 1'b0};
                miso     <= dout[7];
                cnt      <= TX_FIRST;
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                miso     <= tx_shift[7];
                cnt      <= cnt + 5'd1;
                if (tx_last) begin
                    rd_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// Single-port byte RAM driven by 10-bit command words from the slave.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    // Address registers and read port; the two addresses persist across frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (rx_data[9:8])
                    OP_WR_ADDR: wr_addr <= ADDR_SIZE'(rx_data[7:0]);
                    OP_RD_ADDR: rd_addr <= ADDR_SIZE'(rx_data[7:0]);
                    OP_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage write port; contents survive reset so preloaded data stays readable.
    // NOTE: the array has no reset branch on purpose; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && (rx_data[9:8] == OP_WR_DATA)) begin
            mem[wr_addr] <= rx_data[7:0];
        end
    end

endmodule

// Top level: slave and RAM joined by the rx/tx handshake.
module spi_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    spi_slave slave_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (SS_n),
        .mosi     (MOSI),
        .dout     (dout),
        .tx_valid (tx_valid),
        .miso     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) ram_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_spi_wrapper.sv
// Testbench for spi_wrapper: frame-level model of the RAM contents, the two
// address registers and the read-address flag predicts MISO and rx_valid
// every cycle; a few directed frames pin exact byte values.

module tb_spi_wrapper;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso;

    int total = 0;
    int bad   = 0;

    logic [7:0] pre   [256];
    logic [7:0] m_mem [256];
    logic [7:0] m_wr   = 8'h00;
    logic [7:0] m_rd   = 8'h00;
    logic       m_flag = 1'b0;

    logic exp_miso = 1'b0;
    logic exp_rxv  = 1'b0;
    logic chk_on   = 1'b0;

    always #5 clk = ~clk;

    spi_wrapper #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (ss_n),
        .MOSI  (mosi),
        .MISO  (miso)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("miso", miso, exp_miso);
            check("rx_valid", dut.rx_valid, exp_rxv);
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock edge with given inputs; em/er are the outputs required after it.
    task automatic step(input logic ss, input logic mo, input logic em, input logic er);
        ss_n = ss;
        mosi = mo;
        @(posedge clk);
        exp_miso = em;
        exp_rxv  = er;
        #1;
    endtask

    function automatic void ram_apply(input logic [9:0] w);
        case (w[9:8])
            2'b00:   m_wr = w[7:0];
            2'b01:   m_mem[m_wr] = w[7:0];
            2'b10:   m_rd = w[7:0];
            default: ;
        endcase
    endfunction

    // Full frame: select edge, command edge, word bits, then 'tail' extra low edges.
    // cut != 0 raises SS_n after 'cut' word bits. cap collects MISO after E12..E19.
    task automatic frame(input logic cmd, input logic [9:0] word, input int cut,
                         input int tail, output logic [7:0] cap);
        logic       to_rd_data;
        logic       sends;
        logic [7:0] tx_byte;
        logic       e;
        int         nb;
        cap        = 8'h00;
        to_rd_data = cmd && m_flag;
        sends      = to_rd_data && (word[9:8] == 2'b11);
        nb         = (cut != 0) ? cut : 10;
        step(1'b0, rbit(), 1'b0, 1'b0);
        step(1'b0, cmd, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) begin
            step(1'b0, word[9 - i], 1'b0, (cut == 0) && (i == 9));
        end
        if (cut == 0) begin
            tx_byte = m_mem[m_rd];
            ram_apply(word);
            if (cmd && !to_rd_data) m_flag = 1'b1;
            for (int k = 11; k <= 10 + tail; k++) begin
                e = (sends && k >= 12 && k <= 19) ? tx_byte[19 - k] : 1'b0;
                step(1'b0, rbit(), e, 1'b0);
                if (k >= 12 && k <= 19) cap = {cap[6:0], miso};
            end
            if (sends && tail >= 9) m_flag = 1'b0;
        end
        step(1'b1, rbit(), 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) step(1'b1, rbit(), 1'b0, 1'b0);
    endtask

    // Start a frame, then pulse reset after nbits word bits (nbits <= 9).
    task automatic reset_mid(input logic cmd, input logic [9:0] word, input int nbits);
        step(1'b0, rbit(), 1'b0, 1'b0);
        step(1'b0, cmd, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            step(1'b0, word[9 - i], 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        step(1'b1, rbit(), 1'b0, 1'b0);
        rst_n = 1'b1;
        m_wr   = 8'h00;
        m_rd   = 8'h00;
        m_flag = 1'b0;
        check("rst_rx_data", dut.rx_data, 0);
        check("rst_dout", dut.dout, 0);
        check("rst_tx_valid", dut.tx_valid, 0);
        check("rst_miso", miso, 0);
    endtask

    task automatic mem_check_all(input string tag);
        for (int i = 0; i < 256; i++) begin
            check(tag, dut.ram_inst.mem[i], m_mem[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cap;
        for (int i = 0; i < 256; i++) begin
            pre[i]               = 8'($urandom);
            m_mem[i]             = pre[i];
            dut.ram_inst.mem[i]  = pre[i];
        end

        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        check("reset_miso", miso, 0);
        check("reset_rx_valid", dut.rx_valid, 0);
        check("reset_rx_data", dut.rx_data, 0);
        check("reset_dout", dut.dout, 0);
        check("reset_tx_valid", dut.tx_valid, 0);

        // Read-data command with the flag clear only takes the read-address path.
        frame(1'b1, 10'h3FF, 0, 10, cap);
        check("rd_cmd_flag_clear", cap, 8'h00);
        // Flag now set; read address is 0 after reset.
        frame(1'b1, 10'h3FF, 0, 10, cap);
        check("rd_addr0_after_reset", cap, pre[0]);

        // Write 0x55 to 0x07; data frame ends with SS_n rising right at E11.
        frame(1'b0, 10'b00_0000_0111, 0, 2, cap);
        frame(1'b0, 10'b01_0101_0101, 0, 0, cap);
        check("mem07", dut.ram_inst.mem[7], 8'h55);

        frame(1'b1, 10'b10_0000_0111, 0, 1, cap);
        frame(1'b1, 10'b11_1111_1111, 0, 10, cap);
        check("rd07_miso", cap, 8'h55);
        // Flag cleared by the read, so this frame only sets it again.
        frame(1'b1, 10'b11_1111_1111, 0, 10, cap);
        check("flag_cleared", cap, 8'h00);
        frame(1'b1, 10'b11_1111_1111, 0, 10, cap);
        check("rd07_again", cap, 8'h55);

        // Boundary addresses.
        frame(1'b0, 10'b00_0111_1111, 0, 1, cap);
        frame(1'b0, 10'b01_0101_0101, 0, 1, cap);
        check("mem7f", dut.ram_inst.mem[8'h7F], 8'h55);
        frame(1'b1, 10'b10_1111_1111, 0, 1, cap);
        frame(1'b1, 10'b11_0000_0000, 0, 10, cap);
        check("rd_ff_miso", cap, pre[8'hFF]);

        // Write-data frame dropped after five bits leaves memory untouched.
        frame(1'b0, 10'b00_0001_0000, 0, 1, cap);
        frame(1'b0, 10'b01_1010_0101, 5, 0, cap);
        check("abort_mem10", dut.ram_inst.mem[8'h10], pre[8'h10]);
        frame(1'b0, 10'b01_0011_1100, 0, 0, cap);
        check("after_abort_mem10", dut.ram_inst.mem[8'h10], 8'h3C);

        // Reset in the middle of a write-data frame.
        reset_mid(1'b0, 10'b01_1111_0000, 6);
        mem_check_all("mem_after_reset");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_mid(rbit(), 10'($urandom), $urandom_range(0, 9));
            end else begin
                frame(rbit(), 10'($urandom),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 0,
                      $urandom_range(0, 10), cap);
            end
        end
        mem_check_all("mem_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
